spi_reg_controller: RTL and testbench

//  SPI mode-0 controller (initiator) that drives the SCLK/nCS/COPI pins of the on-chip SPI register

---
 rtl/spi_reg_controller_if.sv | 24 ++
 rtl/spi_reg_controller.sv | 114 +++++++++++
 tb/tb_spi_reg_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_controller_if.sv
// Request/handshake and SPI pin bundle for spi_reg_controller.
// master = requester side, slave = the controller itself.
interface spi_reg_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       ncs;
  logic       copi;

  modport master (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, busy, done, sclk, ncs, copi
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, busy, done, sclk, ncs, copi
  );
endinterface

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator: sends one 16-bit frame {rw, addr[6:0], data[7:0]} MSB first
// per accepted request, with programmable SCLK phase length and nCS setup/hold/gap.
module spi_reg_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_controller_if.slave   bus
);

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         bit_cnt;
  logic [15:0]        shreg;
  logic               last_cycle;

  assign last_cycle    = (cnt == CNT_W'(1));
  assign bus.req_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      bus.sclk <= 1'b0;
      bus.ncs  <= 1'b1;
      bus.copi <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            shreg    <= {bus.req_rw, bus.req_addr, bus.req_data};
            bus.copi <= bus.req_rw;
            bus.ncs  <= 1'b0;
            bus.sclk <= 1'b0;
            bus.busy <= 1'b1;
            bit_cnt  <= '0;
            cnt      <= CNT_W'(CS_SETUP);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (last_cycle) begin
            cnt   <= CNT_W'(CLK_DIV);
            state <= SHIFT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SHIFT: begin
          // sclk itself marks the phase; COPI only moves on the falling edge
          if (!last_cycle) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!bus.sclk) begin
            bus.sclk <= 1'b1;
            cnt      <= CNT_W'(CLK_DIV);
          end else begin
            bus.sclk <= 1'b0;
            if (bit_cnt == 5'd15) begin
              cnt   <= CNT_W'(CS_HOLD);
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              shreg    <= {shreg[14:0], 1'b0};
              bus.copi <= shreg[14];
              cnt      <= CNT_W'(CLK_DIV);
            end
          end
        end
        HOLD: begin
          if (last_cycle) begin
            bus.ncs  <= 1'b1;
            bus.copi <= 1'b0;
            bus.done <= 1'b1;
            cnt      <= CNT_W'(CS_GAP);
            state    <= GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (last_cycle) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Randomized scoreboard bench for spi_reg_controller: stimulus queues expected frames,
// a pin-level monitor reassembles each frame from SCLK rises and checks timing.
module tb_spi_reg_controller;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int NCS_LOW  = CS_SETUP + 32 * CLK_DIV + CS_HOLD;

  typedef struct {
    logic [15:0] frame;
    bit          abort;
    bit          gap_chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_reg_controller_if bus ();

  spi_reg_controller #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t        sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned frames_sent = 0;
  int unsigned frames_ended = 0;
  bit          mon_en = 1'b0;
  bit          idle_sclk_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                      input bit abort, input bit gap_chk, input bit hold);
    int unsigned t;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = a;
    bus.req_data  = d;
    t = 0;
    while (!bus.req_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: ready=0 expected 1 after %0d cycles", t);
      bus.req_valid = 1'b0;
      return;
    end
    sbq.push_back('{frame: {rw, a, d}, abort: abort, gap_chk: gap_chk});
    frames_sent++;
    @(posedge clk);
    #1;
    // scramble request fields right after accept; the frame in flight must not change
    bus.req_rw   = ~rw;
    bus.req_addr = ~a;
    bus.req_data = ~d;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // Monitor
  exp_t        cur;
  bit          in_frame = 1'b0;
  logic [15:0] bits;
  int unsigned nbits, low_cyc, cyc, last_rise;
  bit          ready_hi, done_next;
  int unsigned busy_cd;
  logic        prev_ncs, prev_sclk, prev_copi;

  initial begin
    cyc = 0; last_rise = 0; busy_cd = 0; done_next = 1'b0;
    bits = '0; nbits = 0; low_cyc = 0; ready_hi = 1'b0;
    prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (done_next) begin
          check("done_pulse_width", {31'd0, bus.done}, 32'd0);
          done_next = 1'b0;
        end
        if (busy_cd > 0) begin
          busy_cd--;
          if (busy_cd == 1) begin
            check("busy_in_gap", {31'd0, bus.busy}, 32'd1);
            check("ready_in_gap", {31'd0, bus.req_ready}, 32'd0);
          end else if (busy_cd == 0) begin
            check("busy_after_gap", {31'd0, bus.busy}, 32'd0);
          end
        end
        if (bus.ncs === 1'b0 && prev_ncs === 1'b1) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: ncs fell with empty scoreboard");
          end else begin
            cur = sbq.pop_front();
            in_frame = 1'b1;
            bits = '0; nbits = 0; low_cyc = 0; ready_hi = 1'b0;
            if (cur.gap_chk) check("ncs_gap", cyc - last_rise, CS_GAP + 1);
          end
        end
        if (bus.ncs === 1'b0) begin
          low_cyc++;
          if (bus.req_ready !== 1'b0) ready_hi = 1'b1;
          if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
            check("copi_stable_at_rise", {31'd0, bus.copi}, {31'd0, prev_copi});
            bits = {bits[14:0], bus.copi};
            nbits++;
          end
        end else if (bus.sclk !== 1'b0) begin
          idle_sclk_bad = 1'b1;
        end
        if (bus.ncs === 1'b1 && prev_ncs === 1'b0 && in_frame) begin
          in_frame = 1'b0;
          last_rise = cyc;
          frames_ended++;
          if (cur.abort) begin
            check("abort_bits", nbits, 5);
            check("abort_done", {31'd0, bus.done}, 32'd0);
            check("abort_sclk", {31'd0, bus.sclk}, 32'd0);
            check("abort_copi", {31'd0, bus.copi}, 32'd0);
          end else begin
            check("frame", {16'd0, bits}, {16'd0, cur.frame});
            check("sclk_rises", nbits, 16);
            check("ncs_low_cycles", low_cyc, NCS_LOW);
            check("done_at_ncs_rise", {31'd0, bus.done}, 32'd1);
            check("ready_low_in_frame", {31'd0, ready_hi}, 32'd0);
            check("copi_zero_in_gap", {31'd0, bus.copi}, 32'd0);
            busy_cd = CS_GAP;
          end
          done_next = 1'b1;
        end
      end
      prev_ncs  = bus.ncs;
      prev_sclk = bus.sclk;
      prev_copi = bus.copi;
    end
  end

  // Stimulus
  initial begin
    int unsigned r, t;
    logic        p;
    bit          hold, prev_hold;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    repeat (3) @(negedge clk);
    check("ready_in_reset", {31'd0, bus.req_ready}, 32'd0);
    check("reset_ncs",  {31'd0, bus.ncs},  32'd1);
    check("reset_sclk", {31'd0, bus.sclk}, 32'd0);
    check("reset_copi", {31'd0, bus.copi}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);

    send(1'b1, 7'h00, 8'hA5, 1'b0, 1'b0, 1'b0);
    send(1'b1, 7'h01, 8'h3C, 1'b0, 1'b0, 1'b1);
    send(1'b1, 7'h04, 8'h80, 1'b0, 1'b1, 1'b0);

    // reset after the fifth SCLK rise
    send(1'b1, 7'h02, 8'hC3, 1'b1, 1'b0, 1'b0);
    r = 0; t = 0; p = bus.sclk;
    while (r < 5 && t < 500) begin
      @(negedge clk);
      t++;
      if (bus.sclk === 1'b1 && p === 1'b0) r++;
      p = bus.sclk;
    end
    if (r < 5) begin
      n_cmp++;
      n_fail++;
      $display("FAIL abort_wait: saw %0d sclk rises expected 5", r);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("busy_after_abort", {31'd0, bus.busy}, 32'd0);

    send(1'b1, 7'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
    send(1'b0, 7'h00, 8'h55, 1'b0, 1'b0, 1'b0);

    prev_hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      hold = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 1'b0, prev_hold, hold);
      if (!hold) repeat ($urandom_range(0, 6)) @(negedge clk);
      prev_hold = hold;
    end

    t = 0;
    while ((frames_ended != frames_sent || bus.busy !== 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (CS_GAP + 2) @(negedge clk);
    check("all_frames_seen", frames_ended, frames_sent);
    check("scoreboard_empty", sbq.size(), 0);
    check("sclk_idle_while_ncs_high", {31'd0, idle_sclk_bad}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
